i2c_slave_regs: RTL and testbench

I2C responder (slave) that pairs with the team's `i2c_master` on the same two-wire bus. It detects START/STOP, matches a fixed 7-bit address, latches a register pointer, and serves byte writes and reads against an internal 8-bit register file. A local host gets a read port into the register file and a write-notification strobe. Bus pins are open-drain: the block only ever pulls SDA low or releases it.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_slave_regs_if.sv | 23 ++
 rtl/i2c_slave_regfile.sv | 23 ++
 rtl/i2c_slave_regs.sv | 161 ++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding, ACK levels and START/STOP detection helper
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDRESS, ADDR_ACK, REG_PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // returns {start, stop}; SCL must be high on both samples
  function automatic logic [1:0] bus_cond(input logic scl_q, input logic scl_d,
                                          input logic sda_q, input logic sda_d);
    return {scl_q & scl_d & sda_d & ~sda_q, scl_q & scl_d & ~sda_d & sda_q};
  endfunction
endpackage

// File: rtl/i2c_slave_regs_if.sv
// i2c_slave_regs_if: open-drain I2C pins plus host register-file access and write notification
interface i2c_slave_regs_if #(
  parameter int NUM_REGS = 16
);
  localparam int AW = i2c_pkg::addr_w(NUM_REGS);
  logic scl;
  logic SDA_in;
  logic SDA_out;
  logic [AW-1:0] host_addr;
  logic [7:0] host_rdata;
  logic wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic busy;
  modport slave(
    input scl, SDA_in, host_addr,
    output SDA_out, host_rdata, wr_strobe, wr_addr, wr_data, busy
  );
  modport master(
    output scl, SDA_in, host_addr,
    input SDA_out, host_rdata, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: byte register array, one synchronous write port and two asynchronous read ports
module i2c_slave_regfile #(
  parameter int NUM_REGS = 16,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);
  logic [7:0] regs [NUM_REGS];
  always_ff @(posedge clk or negedge reset)
    if (!reset) regs <= '{default: '0};
    else if (we && 32'(waddr) < NUM_REGS) regs[waddr] <= wdata;
  // unimplemented addresses read as all ones
  assign rdata_a = 32'(raddr_a) < NUM_REGS ? regs[raddr_a] : 8'hFF;
  assign rdata_b = 32'(raddr_b) < NUM_REGS ? regs[raddr_b] : 8'hFF;
endmodule

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C responder serving a byte register file; define I2C_SLAVE_AUTOINC_EN
// to advance the register pointer after every acknowledged data byte.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int NUM_REGS = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  input logic enable,
  i2c_slave_regs_if.slave bus
);
  localparam int AW = addr_w(NUM_REGS);
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  state_t state, state_n;
  logic [SYNC_STAGES:0] scl_sh, sda_sh;
  logic [3:0] cnt, cnt_n;
  logic [6:0] sr, sr_n;
  logic [AW-1:0] ptr, ptr_n, ptr_inc;
  logic sda_q, sda_n, rw, rw_n, ok, ok_n, commit;
  logic scl_q, scl_d, sda_s, sda_d, rise, fall, start, stop;
  logic [7:0] rx_byte, rd_byte;
  assign scl_q = scl_sh[SYNC_STAGES-1];
  assign scl_d = scl_sh[SYNC_STAGES];
  assign sda_s = sda_sh[SYNC_STAGES-1];
  assign sda_d = sda_sh[SYNC_STAGES];
  assign {start, stop} = bus_cond(scl_q, scl_d, sda_s, sda_d);
  assign rise = scl_q & ~scl_d;
  assign fall = ~scl_q & scl_d;
  assign rx_byte = {sr, sda_s};
  assign ptr_inc = 32'(ptr) == NUM_REGS - 1 ? '0 : ptr + 1'b1;
  assign bus.SDA_out = sda_q | ~enable;
  assign bus.busy = !(state inside {IDLE, START, ADDRESS} || (state == ADDR_ACK && cnt == 4'd0));
  i2c_slave_regfile #(.NUM_REGS(NUM_REGS), .AW(AW)) u_regs (
    .clk(clk),
    .reset(reset),
    .we(bus.wr_strobe),
    .waddr(bus.wr_addr),
    .wdata(bus.wr_data),
    .raddr_a(bus.host_addr),
    .raddr_b(ptr),
    .rdata_a(bus.host_rdata),
    .rdata_b(rd_byte)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      scl_sh <= '1;
      sda_sh <= '1;
      cnt <= '0;
      sr <= '0;
      ptr <= '0;
      sda_q <= NACK;
      rw <= 1'b0;
      ok <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      state <= state_n;
      scl_sh <= {scl_sh[SYNC_STAGES-1:0], bus.scl};
      sda_sh <= {sda_sh[SYNC_STAGES-1:0], bus.SDA_in};
      cnt <= cnt_n;
      sr <= sr_n;
      ptr <= ptr_n;
      sda_q <= sda_n;
      rw <= rw_n;
      ok <= ok_n;
      bus.wr_strobe <= commit;
      if (commit) begin
        bus.wr_addr <= ptr;
        bus.wr_data <= rx_byte;
      end
    end
  // ack states use cnt as phase: 0 = drive ack on first fall, 1 = finish on second fall
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    ptr_n = ptr;
    sda_n = sda_q;
    rw_n = rw;
    ok_n = ok;
    commit = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      sda_n = NACK;
    end else if (start) begin
      state_n = ADDRESS;
      cnt_n = '0;
      sda_n = NACK;
    end else if (stop) begin
      state_n = IDLE;
      sda_n = NACK;
    end else case (state)
      ADDRESS, REG_PTR, WRITE: if (rise) begin
        sr_n = rx_byte[6:0];
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd7) begin
          cnt_n = '0;
          if (state == ADDRESS) begin
            rw_n = rx_byte[0];
            state_n = rx_byte[7:1] == SLAVE_ADDR ? ADDR_ACK : IDLE;
          end else if (state == REG_PTR) begin
            ok_n = {1'b0, rx_byte} < 9'(NUM_REGS);
            ptr_n = ok_n ? rx_byte[AW-1:0] : ptr;
            state_n = PTR_ACK;
          end else begin
            ok_n = 32'(ptr) < NUM_REGS;
            commit = ok_n;
            state_n = WRITE_ACK;
          end
        end
      end
      ADDR_ACK, PTR_ACK, WRITE_ACK: if (fall) begin
        if (cnt == 4'd0) begin
          sda_n = (state == ADDR_ACK || ok) ? ACK : NACK;
          cnt_n = 4'd1;
        end else if (state == ADDR_ACK && rw) begin
          state_n = READ;
          sda_n = rd_byte[7];
          sr_n = rd_byte[6:0];
          cnt_n = 4'd1;
        end else begin
          sda_n = NACK;
          cnt_n = '0;
          state_n = state == ADDR_ACK ? REG_PTR : ok ? WRITE : IDLE;
          ptr_n = (state == WRITE_ACK && ok && AUTOINC) ? ptr_inc : ptr;
        end
      end
      READ: if (fall) begin
        if (cnt == 4'd8) begin
          sda_n = NACK;
          cnt_n = '0;
          state_n = READ_ACK;
        end else begin
          sda_n = sr[6];
          sr_n = {sr[5:0], 1'b1};
          cnt_n = cnt + 4'd1;
        end
      end
      READ_ACK: if (rise) begin
        if (sda_s == ACK) begin
          cnt_n = 4'd1;
          ptr_n = AUTOINC ? ptr_inc : ptr;
        end else state_n = IDLE;
      end else if (fall && cnt == 4'd1) begin
        state_n = READ;
        sda_n = rd_byte[7];
        sr_n = rd_byte[6:0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-level I2C master driving table vectors and corner-case sequences
module tb_i2c_slave_regs;
  typedef struct {
    logic [6:0] addr;
    logic [7:0] ptr;
    logic [7:0] data;
    logic [2:0] acks;
    int strobes;
    logic [3:0] raddr;
    logic [7:0] rval;
  } vec_t;
  logic clk = 1'b0;
  logic reset, enable, m_sda;
  int tests = 0, fails = 0, strobes = 0, run = 0, max_run = 0;
  logic [3:0] last_a;
  logic [7:0] last_d;
  i2c_slave_regs_if #(.NUM_REGS(16)) bus();
  assign bus.SDA_in = m_sda & bus.SDA_out;
  i2c_slave_regs #(.SLAVE_ADDR(7'h42), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.wr_strobe) begin
      strobes++;
      run++;
      last_a = bus.wr_addr;
      last_d = bus.wr_data;
      if (run > max_run) max_run = run;
    end else run = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic q();
    repeat (10) @(negedge clk);
  endtask
  task automatic start_c();
    m_sda = 1'b1; q();
    bus.scl = 1'b1; q();
    m_sda = 1'b0; q();
    bus.scl = 1'b0; q();
  endtask
  task automatic stop_c();
    m_sda = 1'b0; q();
    bus.scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask
  task automatic bit_x(input logic b, output logic s);
    m_sda = b; q();
    bus.scl = 1'b1; q();
    s = bus.SDA_in; q();
    bus.scl = 1'b0; q();
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask
  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(mack, s);
  endtask
  task automatic host_rd(input logic [3:0] a, output logic [7:0] d);
    bus.host_addr = a;
    @(negedge clk);
    d = bus.host_rdata;
  endtask
  task automatic write_reg(input logic [7:0] p, input logic [7:0] d);
    logic a;
    start_c();
    wr_byte(8'h84, a);
    wr_byte(p, a);
    wr_byte(d, a);
    stop_c();
  endtask
  vec_t v [7];
  initial begin
    logic a, s;
    logic [2:0] got;
    logic [7:0] d;
    logic [7:0] exp2, exp15, exp0;
    int s0;
    v[0] = '{7'h42, 8'h05, 8'hA5, 3'b111, 1, 4'h5, 8'hA5};
    v[1] = '{7'h43, 8'h05, 8'h5A, 3'b000, 0, 4'h5, 8'hA5};
    v[2] = '{7'h42, 8'h20, 8'h77, 3'b100, 0, 4'h0, 8'h00};
    v[3] = '{7'h42, 8'h0F, 8'h3C, 3'b111, 1, 4'hF, 8'h3C};
    v[4] = '{7'h42, 8'h00, 8'h01, 3'b111, 1, 4'h0, 8'h01};
    v[5] = '{7'h42, 8'h10, 8'h99, 3'b100, 0, 4'h0, 8'h01};
    v[6] = '{7'h21, 8'h00, 8'hEE, 3'b000, 0, 4'h0, 8'h01};
    reset = 1'b0;
    enable = 1'b1;
    m_sda = 1'b1;
    bus.scl = 1'b1;
    bus.host_addr = '0;
    repeat (3) @(negedge clk);
    check("rst SDA_out", 32'(bus.SDA_out), 32'(1));
    check("rst busy", 32'(bus.busy), 32'(0));
    check("rst wr_strobe", 32'(bus.wr_strobe), 32'(0));
    check("rst wr_addr", 32'(bus.wr_addr), 32'(0));
    check("rst wr_data", 32'(bus.wr_data), 32'(0));
    check("rst host_rdata", 32'(bus.host_rdata), 32'(0));
    reset = 1'b1;
    q();
    enable = 1'b0;
    start_c();
    wr_byte(8'h84, a);
    stop_c();
    enable = 1'b1;
    q();
    check("disabled addr ack", 32'(a), 32'(0));
    check("disabled strobes", 32'(strobes), 32'(0));
    for (int i = 0; i < 7; i++) begin
      s0 = strobes;
      got = '0;
      start_c();
      wr_byte({v[i].addr, 1'b0}, a);
      got[2] = a;
      check($sformatf("v%0d busy", i), 32'(bus.busy), 32'(v[i].acks[2]));
      if (a) begin
        wr_byte(v[i].ptr, a);
        got[1] = a;
        if (a) begin
          wr_byte(v[i].data, a);
          got[0] = a;
        end
      end
      stop_c();
      q();
      check($sformatf("v%0d acks", i), 32'(got), 32'(v[i].acks));
      check($sformatf("v%0d strobes", i), 32'(strobes - s0), 32'(v[i].strobes));
      if (v[i].strobes > 0)
        check($sformatf("v%0d wr_addr/data", i), 32'({last_a, last_d}), 32'({v[i].ptr[3:0], v[i].data}));
      host_rd(v[i].raddr, d);
      check($sformatf("v%0d host_rdata", i), 32'(d), 32'(v[i].rval));
      check($sformatf("v%0d busy idle", i), 32'(bus.busy), 32'(0));
    end
    write_reg(8'h03, 8'h33);
    write_reg(8'h04, 8'h44);
    start_c();
    wr_byte(8'h84, a);
    wr_byte(8'h03, a);
    check("rd ptr ack", 32'(a), 32'(1));
    start_c();
    wr_byte(8'h85, a);
    check("rd addr ack", 32'(a), 32'(1));
    rd_byte(1'b0, d);
    check("rd byte0", 32'(d), 32'(8'h33));
    rd_byte(1'b1, d);
`ifdef I2C_SLAVE_AUTOINC_EN
    exp2 = 8'h44;
    exp15 = 8'h11;
    exp0 = 8'h22;
`else
    exp2 = 8'h33;
    exp15 = 8'h22;
    exp0 = 8'h01;
`endif
    check("rd byte1", 32'(d), 32'(exp2));
    check("rd released after nack", 32'(bus.SDA_out), 32'(1));
    stop_c();
    check("rd busy after stop", 32'(bus.busy), 32'(0));
    s0 = strobes;
    got = '0;
    start_c();
    wr_byte(8'h84, a);
    wr_byte(8'h0F, a);
    wr_byte(8'h11, a);
    got[1] = a;
    wr_byte(8'h22, a);
    got[0] = a;
    stop_c();
    check("wrap data acks", 32'(got), 32'(3'b011));
    check("wrap strobes", 32'(strobes - s0), 32'(2));
    host_rd(4'hF, d);
    check("wrap reg15", 32'(d), 32'(exp15));
    host_rd(4'h0, d);
    check("wrap reg0", 32'(d), 32'(exp0));
    write_reg(8'h07, 8'h00);
    start_c();
    wr_byte(8'h84, a);
    wr_byte(8'h07, a);
    stop_c();
    start_c();
    wr_byte(8'h85, a);
    bit_x(1'b1, s);
    check("midrd bit7", 32'(s), 32'(0));
    check("midrd driving", 32'(bus.SDA_out), 32'(0));
    check("midrd busy", 32'(bus.busy), 32'(1));
    reset = 1'b0;
    #1;
    check("async rst SDA_out", 32'(bus.SDA_out), 32'(1));
    check("async rst busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    m_sda = 1'b1;
    q();
    bus.scl = 1'b1;
    q();
    host_rd(4'h5, d);
    check("post rst reg5", 32'(d), 32'(0));
    start_c();
    wr_byte(8'h84, a);
    check("post rst addr ack", 32'(a), 32'(1));
    check("post rst busy", 32'(bus.busy), 32'(1));
    stop_c();
    check("post rst busy stop", 32'(bus.busy), 32'(0));
    check("strobe width", 32'(max_run), 32'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
